// File: rtl/key_entry_buffer.sv
// key_entry_buffer
// Keypad entry buffer for the alarm clock key path. Accepted key digits shift
// in at the least-significant position. Backspace removes the most recent
// digit and clear empties the buffer. Out-of-range keys are rejected, as are
// keys arriving while the buffer is full when OVERWRITE=0. An optional
// inactivity timeout auto-clears a partly or fully entered buffer.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   shift_i      one-cycle strobe: shift in key_i
//   key_i        key code, sampled while shift_i=1
//   backspace_i  one-cycle strobe: remove the most recently entered digit
//   clear_i      one-cycle strobe: empty the buffer
//   digits_o     buffer contents; digit i at [i*KEY_W +: KEY_W]
//   count_o      number of valid digits, 0..DIGITS
//   state_o      2'b00 IDLE, 2'b01 ENTRY, 2'b10 FULL
//   full_o       count_o == DIGITS
//   reject_o     one-cycle pulse: a key strobe was ignored
//   timeout_o    one-cycle pulse: buffer auto-cleared by inactivity
module key_entry_buffer #(
  parameter int DIGITS      = 4,
  parameter int KEY_W       = 4,
  parameter int MAX_KEY     = 9,
  parameter bit OVERWRITE   = 1'b1,
  parameter int TIMEOUT_CYC = 0,
  parameter int CNT_W       = $clog2(DIGITS + 1),
  parameter int TO_W        = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      shift_i,
  input  logic [KEY_W-1:0]          key_i,
  input  logic                      backspace_i,
  input  logic                      clear_i,
  output logic [DIGITS*KEY_W-1:0]   digits_o,
  output logic [CNT_W-1:0]          count_o,
  output logic [1:0]                state_o,
  output logic                      full_o,
  output logic                      reject_o,
  output logic                      timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ENTRY = 2'b01,
    S_FULL  = 2'b10
  } state_t;

  localparam int                DW       = DIGITS * KEY_W;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DIGITS);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam bit                TO_EN    = (TIMEOUT_CYC > 0);

  logic [DW-1:0]    digits_q, digits_d;
  logic [CNT_W-1:0] count_q,  count_d;
  state_t           state_q,  state_d;
  logic             full_q,   full_d;
  logic             reject_q, reject_d;
  logic             timeout_q, timeout_d;
  logic [TO_W-1:0]  tcnt_q,   tcnt_d;

  logic             key_ok_s;
  logic             is_full_s;
  logic             any_strobe_s;
  logic             expire_s;
  logic [TO_W-1:0]  tcnt_idle_s;

  // Shared decode of the current cycle's conditions.
  always_comb begin
    key_ok_s     = (32'(key_i) <= 32'(MAX_KEY));
    is_full_s    = (count_q == CNT_FULL);
    any_strobe_s = clear_i | backspace_i | shift_i;
    // >= rather than ==: a rejected shift on the expiry cycle blocks the
    // timeout but keeps counting, so expiry is taken on the next free cycle.
    expire_s     = TO_EN && (count_q != '0) && (tcnt_q >= TO_LAST);
    // Inactivity counter value when nothing restarts it: runs while digits
    // are held, sits at zero while the buffer is empty or timeout disabled.
    if (TO_EN && (count_q != '0)) begin
      tcnt_idle_s = tcnt_q + TO_W'(1);
    end else begin
      tcnt_idle_s = '0;
    end
  end

  // Buffer, count and timeout next-state; clear > backspace > shift > expiry.
  always_comb begin
    digits_d  = digits_q;
    count_d   = count_q;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    tcnt_d    = tcnt_idle_s;
    if (clear_i) begin
      digits_d = '0;
      count_d  = '0;
      tcnt_d   = '0;
    end else if (backspace_i) begin
      tcnt_d = '0;
      if (count_q != '0) begin
        digits_d = {{KEY_W{1'b0}}, digits_q[DW-1:KEY_W]};
        count_d  = count_q - CNT_W'(1);
      end else begin
        digits_d = digits_q;
      end
    end else if (shift_i) begin
      if (key_ok_s && (!is_full_s || OVERWRITE)) begin
        digits_d = {digits_q[DW-KEY_W-1:0], key_i};
        count_d  = is_full_s ? count_q : (count_q + CNT_W'(1));
        tcnt_d   = '0;
      end else begin
        // Rejected key leaves the inactivity counter running.
        reject_d = 1'b1;
      end
    end else if (expire_s) begin
      digits_d  = '0;
      count_d   = '0;
      timeout_d = 1'b1;
      tcnt_d    = '0;
    end else begin
      tcnt_d = tcnt_idle_s;
    end
  end

  // Entry state follows the next count, so it only moves when count moves.
  always_comb begin
    if (count_d == '0) begin
      state_d = S_IDLE;
    end else if (count_d == CNT_FULL) begin
      state_d = S_FULL;
    end else begin
      state_d = S_ENTRY;
    end
    full_d = (count_d == CNT_FULL);
  end

  // State register with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digits_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      full_q    <= 1'b0;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      digits_q  <= digits_d;
      count_q   <= count_d;
      state_q   <= state_d;
      full_q    <= full_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign digits_o  = digits_q;
  assign count_o   = count_q;
  assign state_o   = state_q;
  assign full_o    = full_q;
  assign reject_o  = reject_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Directed testbench for key_entry_buffer. Three instances share the stimulus:
// ow (OVERWRITE=1, no timeout), nw (OVERWRITE=0, no timeout) and
// to (OVERWRITE=1, TIMEOUT_CYC=8).
module tb_key_entry_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        shift = 1'b0;
  logic [3:0]  key = 4'd0;
  logic        backspace = 1'b0;
  logic        clear = 1'b0;

  logic [15:0] ow_digits, nw_digits, to_digits;
  logic [2:0]  ow_count, nw_count, to_count;
  logic [1:0]  ow_state, nw_state, to_state;
  logic        ow_full, nw_full, to_full;
  logic        ow_reject, nw_reject, to_reject;
  logic        ow_timeout, nw_timeout, to_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  key_entry_buffer #(.OVERWRITE(1'b1), .TIMEOUT_CYC(0)) dut_ow (
    .clock(clock), .reset(reset), .shift_i(shift), .key_i(key),
    .backspace_i(backspace), .clear_i(clear), .digits_o(ow_digits),
    .count_o(ow_count), .state_o(ow_state), .full_o(ow_full),
    .reject_o(ow_reject), .timeout_o(ow_timeout));

  key_entry_buffer #(.OVERWRITE(1'b0), .TIMEOUT_CYC(0)) dut_nw (
    .clock(clock), .reset(reset), .shift_i(shift), .key_i(key),
    .backspace_i(backspace), .clear_i(clear), .digits_o(nw_digits),
    .count_o(nw_count), .state_o(nw_state), .full_o(nw_full),
    .reject_o(nw_reject), .timeout_o(nw_timeout));

  key_entry_buffer #(.OVERWRITE(1'b1), .TIMEOUT_CYC(8)) dut_to (
    .clock(clock), .reset(reset), .shift_i(shift), .key_i(key),
    .backspace_i(backspace), .clear_i(clear), .digits_o(to_digits),
    .count_o(to_count), .state_o(to_state), .full_o(to_full),
    .reject_o(to_reject), .timeout_o(to_timeout));

  task automatic step();
    @(posedge clock);
    #1;
    shift = 1'b0;
    backspace = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_shift(input logic [3:0] k);
    shift = 1'b1;
    key = k;
    step();
  endtask

  task automatic do_backspace();
    backspace = 1'b1;
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({ow_digits, ow_count, ow_state, ow_full, ow_reject, ow_timeout} !== 25'd0) begin
      $display("FAIL reset_ow got d=%h c=%0d s=%0d f=%b r=%b t=%b want all 0",
               ow_digits, ow_count, ow_state, ow_full, ow_reject, ow_timeout);
      errors++;
    end
    checks++;
    if ({to_digits, to_count, to_state, to_full, to_reject, to_timeout} !== 25'd0) begin
      $display("FAIL reset_to got d=%h c=%0d s=%0d want all 0", to_digits, to_count, to_state);
      errors++;
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_fill();
    do_shift(4'd1);
    checks++;
    if (ow_count !== 3'd1 || ow_state !== 2'b01 || ow_digits !== 16'h0001) begin
      $display("FAIL fill_first got d=%h c=%0d s=%0d want 0001 1 1", ow_digits, ow_count, ow_state);
      errors++;
    end
    do_shift(4'd2);
    do_shift(4'd3);
    do_shift(4'd4);
    checks++;
    if (ow_digits !== 16'h1234 || ow_count !== 3'd4 || ow_full !== 1'b1 || ow_state !== 2'b10) begin
      $display("FAIL fill_ow got d=%h c=%0d f=%b s=%0d want 1234 4 1 2",
               ow_digits, ow_count, ow_full, ow_state);
      errors++;
    end
    checks++;
    if (nw_digits !== 16'h1234 || nw_count !== 3'd4 || nw_full !== 1'b1 || nw_reject !== 1'b0) begin
      $display("FAIL fill_nw got d=%h c=%0d f=%b r=%b want 1234 4 1 0",
               nw_digits, nw_count, nw_full, nw_reject);
      errors++;
    end
  endtask

  task automatic test_overwrite();
    do_shift(4'd5);
    checks++;
    if (ow_digits !== 16'h2345 || ow_count !== 3'd4 || ow_reject !== 1'b0) begin
      $display("FAIL overwrite_ow got d=%h c=%0d r=%b want 2345 4 0", ow_digits, ow_count, ow_reject);
      errors++;
    end
    checks++;
    if (nw_digits !== 16'h1234 || nw_count !== 3'd4 || nw_reject !== 1'b1) begin
      $display("FAIL overwrite_nw got d=%h c=%0d r=%b want 1234 4 1", nw_digits, nw_count, nw_reject);
      errors++;
    end
    step();
    checks++;
    if (nw_reject !== 1'b0) begin
      $display("FAIL reject_one_cycle got r=%b want 0", nw_reject);
      errors++;
    end
  endtask

  task automatic test_backspace();
    do_clear();
    do_shift(4'd1);
    do_shift(4'd2);
    do_shift(4'd3);
    do_shift(4'd4);
    do_backspace();
    checks++;
    if (ow_digits !== 16'h0123 || ow_count !== 3'd3) begin
      $display("FAIL bksp_1 got d=%h c=%0d want 0123 3", ow_digits, ow_count);
      errors++;
    end
    do_backspace();
    checks++;
    if (ow_digits !== 16'h0012 || ow_count !== 3'd2 || ow_state !== 2'b01 || ow_full !== 1'b0) begin
      $display("FAIL bksp_2 got d=%h c=%0d s=%0d f=%b want 0012 2 1 0",
               ow_digits, ow_count, ow_state, ow_full);
      errors++;
    end
    for (int i = 0; i < 3; i++) begin
      do_backspace();
      checks++;
      if (ow_reject !== 1'b0 || nw_reject !== 1'b0) begin
        $display("FAIL bksp_noreject_%0d got r=%b/%b want 0", i, ow_reject, nw_reject);
        errors++;
      end
    end
    checks++;
    if (ow_digits !== 16'h0000 || ow_count !== 3'd0 || ow_state !== 2'b00) begin
      $display("FAIL bksp_empty got d=%h c=%0d s=%0d want 0000 0 0", ow_digits, ow_count, ow_state);
      errors++;
    end
  endtask

  task automatic test_reject_and_priority();
    do_shift(4'd1);
    do_shift(4'd2);
    do_shift(4'hA);
    checks++;
    if (ow_reject !== 1'b1 || ow_digits !== 16'h0012 || ow_count !== 3'd2) begin
      $display("FAIL bad_key got r=%b d=%h c=%0d want 1 0012 2", ow_reject, ow_digits, ow_count);
      errors++;
    end
    step();
    checks++;
    if (ow_reject !== 1'b0) begin
      $display("FAIL bad_key_pulse got r=%b want 0", ow_reject);
      errors++;
    end
    clear = 1'b1;
    backspace = 1'b1;
    shift = 1'b1;
    key = 4'd5;
    step();
    checks++;
    if (ow_digits !== 16'h0000 || ow_count !== 3'd0 || ow_state !== 2'b00 || ow_reject !== 1'b0) begin
      $display("FAIL priority_clear got d=%h c=%0d s=%0d r=%b want 0000 0 0 0",
               ow_digits, ow_count, ow_state, ow_reject);
      errors++;
    end
    // Backspace beats shift: 0012 -> 0001, the shift key is dropped.
    do_shift(4'd1);
    do_shift(4'd2);
    backspace = 1'b1;
    shift = 1'b1;
    key = 4'd7;
    step();
    checks++;
    if (ow_digits !== 16'h0001 || ow_count !== 3'd1 || ow_reject !== 1'b0) begin
      $display("FAIL priority_bksp got d=%h c=%0d r=%b want 0001 1 0", ow_digits, ow_count, ow_reject);
      errors++;
    end
  endtask

  task automatic test_timeout();
    int tpulses;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    do_shift(4'd7);
    tpulses = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (to_timeout === 1'b1) tpulses++;
    end
    checks++;
    if (tpulses !== 0 || to_count !== 3'd1) begin
      $display("FAIL timeout_early got pulses=%0d c=%0d want 0 1", tpulses, to_count);
      errors++;
    end
    step();
    checks++;
    if (to_timeout !== 1'b1 || to_digits !== 16'h0000 || to_count !== 3'd0 || to_state !== 2'b00) begin
      $display("FAIL timeout_fire got t=%b d=%h c=%0d s=%0d want 1 0000 0 0",
               to_timeout, to_digits, to_count, to_state);
      errors++;
    end
    tpulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (to_timeout === 1'b1) tpulses++;
    end
    checks++;
    if (tpulses !== 0) begin
      $display("FAIL timeout_once got extra pulses=%0d want 0", tpulses);
      errors++;
    end
    // Shift on the expiry cycle wins.
    do_shift(4'd7);
    for (int i = 0; i < 7; i++) step();
    do_shift(4'd7);
    checks++;
    if (to_timeout !== 1'b0 || to_digits !== 16'h0077 || to_count !== 3'd2) begin
      $display("FAIL timeout_strobe_wins got t=%b d=%h c=%0d want 0 0077 2",
               to_timeout, to_digits, to_count);
      errors++;
    end
    // A rejected key does not restart the count: expiry 8 cycles after the last accepted shift.
    do_clear();
    do_shift(4'd3);
    for (int i = 0; i < 3; i++) step();
    do_shift(4'hF);
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (to_timeout !== 1'b0 || to_count !== 3'd1) begin
      $display("FAIL timeout_reject_pre got t=%b c=%0d want 0 1", to_timeout, to_count);
      errors++;
    end
    step();
    checks++;
    if (to_timeout !== 1'b1 || to_count !== 3'd0) begin
      $display("FAIL timeout_reject_norestart got t=%b c=%0d want 1 0", to_timeout, to_count);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    do_shift(4'd1);
    do_shift(4'd2);
    do_shift(4'd3);
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({to_digits, to_count, to_state, to_full, to_reject, to_timeout} !== 25'd0 ||
        ow_count !== 3'd0) begin
      $display("FAIL async_reset got d=%h c=%0d s=%0d ow_c=%0d want 0",
               to_digits, to_count, to_state, ow_count);
      errors++;
    end
    #1;
    reset = 1'b0;
    step();
    do_shift(4'd5);
    checks++;
    if (to_count !== 3'd1 || to_digits !== 16'h0005 || to_state !== 2'b01) begin
      $display("FAIL post_reset_shift got c=%0d d=%h s=%0d want 1 0005 1",
               to_count, to_digits, to_state);
      errors++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_overwrite();
    test_backspace();
    test_reject_and_priority();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
